audio_pll_reset_sequencer: RTL and testbench

Controls the reset and lock-qualification sequence of the audio PLL (50 MHz reference to 18.432 MHz audio clock).
- Holds the PLL in reset for a fixed time after power-up, then waits for lock with a timeout and retries a bounded number of times.
- Requires lock to be stable before releasing the downstream audio reset.
- Re-sequences automatically on loss of lock.
- Sits in the 50 MHz reference-clock domain between the PLL wrapper and the audio codec/I2S cores.

---
 rtl/audio_pll_reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_audio_pll_reset_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pll_reset_sequencer.sv
// Audio PLL reset and lock-qualification sequencer (50 MHz reference domain).
// Holds the PLL in reset, waits for lock with bounded retries, and qualifies lock before releasing the audio cores.
//
// state      | meaning
// RESET_HOLD | pll_rst asserted for RST_HOLD_CYCLES
// WAIT_LOCK  | PLL running, waiting for synchronized lock, with timeout
// STABILIZE  | lock must stay high for LOCK_STABLE_CYCLES consecutive cycles
// RUN        | audio reset released, ready asserted
// FAULT      | retries exhausted, PLL held in reset until restart
module audio_pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 500,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       audio_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABILIZE  = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           state;
    state_t           state_nxt;
    logic             lock_meta;
    logic             lk;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic [7:0]       loss_nxt;

    // pll_locked is asynchronous to clk; only lk is used past this point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lk        <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lk        <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RESET_HOLD;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            audio_rst_n   <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            pll_rst       <= (state_nxt == RESET_HOLD) || (state_nxt == FAULT);
            audio_rst_n   <= (state_nxt == RUN);
            ready         <= (state_nxt == RUN);
            fault         <= (state_nxt == FAULT);
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        cnt_nxt   = cnt;
        // restart overrides every same-cycle event, including timeouts
        if (restart) begin
            state_nxt = RESET_HOLD;
            retry_nxt = '0;
        end else begin
            case (state)
                RESET_HOLD: begin
                    if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_nxt = STABILIZE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_nxt = retry_cnt + 4'd1;
                            state_nxt = RESET_HOLD;
                        end else begin
                            state_nxt = FAULT;
                        end
                    end
                end
                STABILIZE: begin
                    if (!lk) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
                        retry_nxt = '0;
                        state_nxt = RESET_HOLD;
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = RESET_HOLD;
                end
            endcase
        end

        if (restart || (state_nxt != state)) begin
            cnt_nxt = '0;
        end else if ((state == RESET_HOLD) || (state == WAIT_LOCK) || (state == STABILIZE)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_pll_reset_sequencer.sv
// Directed bench for audio_pll_reset_sequencer with short timing parameters.
// Expected cycle counts are derived from the sequencer behaviour with a 2-flop lock synchronizer.
module tb_audio_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       audio_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int vectors     = 0;
    int miscompares = 0;

    audio_pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .restart      (restart),
        .pll_rst      (pll_rst),
        .audio_rst_n  (audio_rst_n),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sigval(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return audio_rst_n;
            2:       return ready;
            default: return fault;
        endcase
    endfunction

    // Ticks until the selected output reaches val; n is the number of edges taken.
    task automatic wait_sig(input int sel, input logic val, input int max, input string tag, output int n);
        n = 0;
        while ((sigval(sel) !== val) && (n < max)) begin
            tick();
            n++;
        end
        chk(tag, 32'(sigval(sel)), 32'(val));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        repeat (3) tick();

        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_audio_rst_n", 32'(audio_rst_n), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_loss", 32'(lock_loss_cnt), 0);

        // Timeout and retry into FAULT with lock held low
        reset_n = 1'b1;
        for (int a = 0; a < 3; a++) begin
            chk("to_retry_hold", 32'(retry_cnt), 32'(a));
            wait_sig(0, 1'b0, 50, "to_hold_end", n);
            chk("to_hold_len", 32'(n), 4);
            chk("to_retry_wait", 32'(retry_cnt), 32'(a));
            if (a < 2) begin
                wait_sig(0, 1'b1, 50, "to_wait_end", n);
                chk("to_wait_len", 32'(n), 20);
            end else begin
                wait_sig(3, 1'b1, 50, "to_fault", n);
                chk("to_fault_len", 32'(n), 20);
            end
        end
        chk("fault_pll_rst", 32'(pll_rst), 1);
        chk("fault_ready", 32'(ready), 0);
        chk("fault_retry", 32'(retry_cnt), 2);
        pll_locked = 1'b1;
        repeat (30) tick();
        chk("fault_sticky", 32'(fault), 1);
        chk("fault_sticky_pll_rst", 32'(pll_rst), 1);

        // Restart out of FAULT, then bring-up with lk already high
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_fault_clr", 32'(fault), 0);
        chk("rs_retry_clr", 32'(retry_cnt), 0);
        chk("rs_pll_rst", 32'(pll_rst), 1);
        wait_sig(0, 1'b0, 50, "bu_hold_end", n);
        chk("bu_hold_len", 32'(n), 4);
        wait_sig(1, 1'b1, 50, "bu_run", n);
        chk("bu_run_len", 32'(n), 9);
        chk("bu_ready", 32'(ready), 1);
        chk("bu_retry", 32'(retry_cnt), 0);

        // Loss of lock in RUN: lk lags 2 edges, the FSM acts on the next one
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("ll_ready_still", 32'(ready), 1);
        tick();
        chk("ll_ready", 32'(ready), 0);
        chk("ll_audio", 32'(audio_rst_n), 0);
        chk("ll_pll_rst", 32'(pll_rst), 1);
        chk("ll_loss", 32'(lock_loss_cnt), 1);

        // Stabilize glitch, with retry_cnt at 1 so "unchanged" is visible
        wait_sig(0, 1'b0, 50, "gl_hold1", n);
        wait_sig(0, 1'b1, 50, "gl_timeout", n);
        chk("gl_timeout_len", 32'(n), 20);
        chk("gl_retry1", 32'(retry_cnt), 1);
        wait_sig(0, 1'b0, 50, "gl_hold2", n);
        chk("gl_hold2_len", 32'(n), 4);
        pll_locked = 1'b1;
        repeat (6) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (6) tick();
        chk("gl_retry_kept", 32'(retry_cnt), 1);
        chk("gl_audio_mid", 32'(audio_rst_n), 0);
        repeat (4) tick();
        chk("gl_audio_pre", 32'(audio_rst_n), 0);
        tick();
        chk("gl_audio_run", 32'(audio_rst_n), 1);
        chk("gl_ready_run", 32'(ready), 1);
        chk("gl_retry_run", 32'(retry_cnt), 0);

        // Saturation of lock_loss_cnt over 300 further losses
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            wait_sig(2, 1'b0, 10, "sat_drop", n);
            pll_locked = 1'b1;
            wait_sig(2, 1'b1, 40, "sat_relock", n);
            if (i == 100) chk("sat_loss_102", 32'(lock_loss_cnt), 102);
        end
        chk("sat_loss_255", 32'(lock_loss_cnt), 255);

        // Restart from RUN keeps lock_loss_cnt
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rr_ready", 32'(ready), 0);
        chk("rr_pll_rst", 32'(pll_rst), 1);
        chk("rr_loss_kept", 32'(lock_loss_cnt), 255);

        // Restart in the same cycle as the final timeout that would enter FAULT
        pll_locked = 1'b0;
        for (int a = 0; a < 2; a++) begin
            wait_sig(0, 1'b0, 50, "rt_hold", n);
            wait_sig(0, 1'b1, 50, "rt_wait", n);
        end
        wait_sig(0, 1'b0, 50, "rt_hold3", n);
        chk("rt_retry2", 32'(retry_cnt), 2);
        repeat (19) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rt_fault", 32'(fault), 0);
        chk("rt_retry", 32'(retry_cnt), 0);
        chk("rt_pll_rst", 32'(pll_rst), 1);
        chk("rt_loss_kept", 32'(lock_loss_cnt), 255);

        // Restart held for several cycles pins cnt at 0
        restart = 1'b1;
        repeat (3) tick();
        restart = 1'b0;
        wait_sig(0, 1'b0, 50, "rh_hold_end", n);
        chk("rh_hold_len", 32'(n), 4);

        // Async reset in the middle of STABILIZE
        pll_locked = 1'b1;
        repeat (5) tick();
        chk("ar_pre_pll_rst", 32'(pll_rst), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_pll_rst", 32'(pll_rst), 1);
        chk("ar_audio", 32'(audio_rst_n), 0);
        chk("ar_ready", 32'(ready), 0);
        chk("ar_fault", 32'(fault), 0);
        chk("ar_retry", 32'(retry_cnt), 0);
        chk("ar_loss", 32'(lock_loss_cnt), 0);

        // Nominal bring-up from reset release with lock tied high
        tick();
        reset_n = 1'b1;
        wait_sig(0, 1'b0, 50, "nm_hold_end", n);
        chk("nm_hold_len", 32'(n), 4);
        wait_sig(1, 1'b1, 50, "nm_run", n);
        chk("nm_run_len", 32'(n), 9);
        chk("nm_ready", 32'(ready), 1);
        chk("nm_retry", 32'(retry_cnt), 0);
        chk("nm_loss", 32'(lock_loss_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
